// File: rtl/cp0_reg.sv
// CP0 register file: Count/Compare timer, Status, Cause, EPC and BadVAddr,
// with MTC0 writes, MFC0 reads and M-stage exception/ERET updates.
module cp0_reg (
    input  logic        clk,
    input  logic        resetn,
    input  logic        we_i,
    input  logic [4:0]  waddr_i,
    input  logic [4:0]  raddr_i,
    input  logic [31:0] data_i,
    input  logic [5:0]  int_i,
    input  logic [31:0] excepttype_i,
    input  logic [31:0] pc_i,
    input  logic        in_delayslot_i,
    input  logic [31:0] bad_addr_i,
    output logic [31:0] data_o,
    output logic [31:0] count_o,
    output logic [31:0] compare_o,
    output logic [31:0] status_o,
    output logic [31:0] cause_o,
    output logic [31:0] epc_o,
    output logic [31:0] badvaddr_o,
    output logic        timer_int_o
);

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 5;

    localparam logic [AW-1:0] REG_BADVADDR = AW'(8);
    localparam logic [AW-1:0] REG_COUNT    = AW'(9);
    localparam logic [AW-1:0] REG_COMPARE  = AW'(11);
    localparam logic [AW-1:0] REG_STATUS   = AW'(12);
    localparam logic [AW-1:0] REG_CAUSE    = AW'(13);
    localparam logic [AW-1:0] REG_EPC      = AW'(14);

    localparam logic [DW-1:0] EXC_INT     = DW'(32'h1);
    localparam logic [DW-1:0] EXC_ADEL    = DW'(32'h4);
    localparam logic [DW-1:0] EXC_ADES    = DW'(32'h5);
    localparam logic [DW-1:0] EXC_SYS     = DW'(32'h8);
    localparam logic [DW-1:0] EXC_BP      = DW'(32'h9);
    localparam logic [DW-1:0] EXC_RI      = DW'(32'ha);
    localparam logic [DW-1:0] EXC_OV      = DW'(32'hc);
    localparam logic [DW-1:0] EXC_ERET    = DW'(32'he);

    // Architectural state; constant Status/Cause bits are not stored
    logic           r_tick;
    logic [DW-1:0]  r_count;
    logic [DW-1:0]  r_compare;
    logic           r_timer_int;
    logic [7:0]     r_status_im;
    logic           r_status_exl;
    logic           r_status_ie;
    logic           r_cause_bd;
    logic [5:0]     r_cause_ip_hw;
    logic [1:0]     r_cause_ip_sw;
    logic [4:0]     r_cause_exccode;
    logic [DW-1:0]  r_epc;
    logic [DW-1:0]  r_badvaddr;

    logic           w_exc_any;
    logic           w_wr;
    logic           w_exc_take;
    logic           w_exc_badaddr;
    logic           w_eret;
    logic [4:0]     w_exccode;

    // An exception of any kind cancels the MTC0 in the same cycle
    assign w_exc_any = (excepttype_i != '0);
    assign w_wr      = we_i & ~w_exc_any;
    assign w_eret    = (excepttype_i == EXC_ERET);

    // Decode the recognised exception codes into an ExcCode value
    always_comb begin
        w_exc_take    = 1'b0;
        w_exc_badaddr = 1'b0;
        w_exccode     = 5'd0;
        case (excepttype_i)
            EXC_INT:  begin w_exc_take = 1'b1; w_exccode = 5'h00; end
            EXC_ADEL: begin w_exc_take = 1'b1; w_exccode = 5'h04; w_exc_badaddr = 1'b1; end
            EXC_ADES: begin w_exc_take = 1'b1; w_exccode = 5'h05; w_exc_badaddr = 1'b1; end
            EXC_SYS:  begin w_exc_take = 1'b1; w_exccode = 5'h08; end
            EXC_BP:   begin w_exc_take = 1'b1; w_exccode = 5'h09; end
            EXC_RI:   begin w_exc_take = 1'b1; w_exccode = 5'h0a; end
            EXC_OV:   begin w_exc_take = 1'b1; w_exccode = 5'h0c; end
            default:  begin w_exc_take = 1'b0; w_exccode = 5'h00; end
        endcase
    end

    // Count advances every second cycle; an MTC0 to Count wins and realigns the tick
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_tick  <= 1'b0;
            r_count <= '0;
        end else if (w_wr && (waddr_i == REG_COUNT)) begin
            r_tick  <= 1'b0;
            r_count <= data_i;
        end else begin
            r_tick <= ~r_tick;
            if (r_tick) begin
                r_count <= r_count + DW'(1);
            end
        end
    end

    // Compare register and sticky timer interrupt; writing Compare acknowledges it
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_compare   <= '0;
            r_timer_int <= 1'b0;
        end else if (w_wr && (waddr_i == REG_COMPARE)) begin
            r_compare   <= data_i;
            r_timer_int <= 1'b0;
        end else if ((r_count == r_compare) && (r_compare != '0)) begin
            r_timer_int <= 1'b1;
        end
    end

    // Status: exception sets EXL, ERET clears it, MTC0 touches IM/EXL/IE only
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_status_im  <= '0;
            r_status_exl <= 1'b0;
            r_status_ie  <= 1'b0;
        end else if (w_exc_take) begin
            r_status_exl <= 1'b1;
        end else if (w_eret) begin
            r_status_exl <= 1'b0;
        end else if (w_wr && (waddr_i == REG_STATUS)) begin
            r_status_im  <= data_i[15:8];
            r_status_exl <= data_i[1];
            r_status_ie  <= data_i[0];
        end
    end

    // Cause: pending lines sampled every cycle, ExcCode/BD on exception, IP[1:0] by MTC0
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_cause_bd      <= 1'b0;
            r_cause_ip_hw   <= '0;
            r_cause_ip_sw   <= '0;
            r_cause_exccode <= '0;
        end else begin
            r_cause_ip_hw <= {int_i[5] | r_timer_int, int_i[4:0]};
            if (w_exc_take) begin
                r_cause_exccode <= w_exccode;
                if (!r_status_exl) begin
                    r_cause_bd <= in_delayslot_i;
                end
            end else if (w_wr && (waddr_i == REG_CAUSE)) begin
                r_cause_ip_sw <= data_i[9:8];
            end
        end
    end

    // EPC: captured only on a first-level exception, otherwise MTC0-writable
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_epc <= '0;
        end else if (w_exc_take) begin
            if (!r_status_exl) begin
                r_epc <= in_delayslot_i ? (pc_i - DW'(4)) : pc_i;
            end
        end else if (w_wr && (waddr_i == REG_EPC)) begin
            r_epc <= data_i;
        end
    end

    // BadVAddr: loaded only by address-error exceptions
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_badvaddr <= '0;
        end else if (w_exc_take && w_exc_badaddr) begin
            r_badvaddr <= bad_addr_i;
        end
    end

    assign count_o     = r_count;
    assign compare_o   = r_compare;
    assign status_o    = {9'b0, 1'b1, 6'b0, r_status_im, 6'b0, r_status_exl, r_status_ie};
    assign cause_o     = {r_cause_bd, r_timer_int, 14'b0, r_cause_ip_hw, r_cause_ip_sw,
                          1'b0, r_cause_exccode, 2'b0};
    assign epc_o       = r_epc;
    assign badvaddr_o  = r_badvaddr;
    assign timer_int_o = r_timer_int;

    // MFC0 read port: current register contents, no write bypass
    always_comb begin
        data_o = '0;
        case (raddr_i)
            REG_BADVADDR: data_o = r_badvaddr;
            REG_COUNT:    data_o = r_count;
            REG_COMPARE:  data_o = r_compare;
            REG_STATUS:   data_o = status_o;
            REG_CAUSE:    data_o = cause_o;
            REG_EPC:      data_o = r_epc;
            default:      data_o = '0;
        endcase
    end

endmodule

// File: tb/tb_cp0_reg.sv
// Scoreboard bench for cp0_reg: a driver applies one input set per cycle and
// pushes the reference model's predicted post-edge state; a monitor compares.
module tb_cp0_reg;

    logic        clk = 1'b0;
    logic        resetn;
    logic        we_i;
    logic [4:0]  waddr_i;
    logic [4:0]  raddr_i;
    logic [31:0] data_i;
    logic [5:0]  int_i;
    logic [31:0] excepttype_i;
    logic [31:0] pc_i;
    logic        in_delayslot_i;
    logic [31:0] bad_addr_i;
    logic [31:0] data_o, count_o, compare_o, status_o, cause_o, epc_o, badvaddr_o;
    logic        timer_int_o;

    always #5 clk = ~clk;

    cp0_reg dut (
        .clk(clk), .resetn(resetn), .we_i(we_i), .waddr_i(waddr_i), .raddr_i(raddr_i),
        .data_i(data_i), .int_i(int_i), .excepttype_i(excepttype_i), .pc_i(pc_i),
        .in_delayslot_i(in_delayslot_i), .bad_addr_i(bad_addr_i), .data_o(data_o),
        .count_o(count_o), .compare_o(compare_o), .status_o(status_o), .cause_o(cause_o),
        .epc_o(epc_o), .badvaddr_o(badvaddr_o), .timer_int_o(timer_int_o)
    );

    typedef struct {
        logic [31:0] count, compare, status, cause, epc, badv, data;
        logic        timer;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model state (architectural view, whole 32-bit registers)
    logic        m_tick;
    logic [31:0] m_count, m_compare, m_status, m_cause, m_epc, m_badv;
    logic        m_timer;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_cause_view();
        logic [31:0] c;
        c = m_cause;
        c[30] = m_timer;
        return c;
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
        case (a)
            5'd8:    return m_badv;
            5'd9:    return m_count;
            5'd11:   return m_compare;
            5'd12:   return m_status;
            5'd13:   return m_cause_view();
            5'd14:   return m_epc;
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_reset();
        m_tick = 1'b0; m_count = 0; m_compare = 0; m_status = 32'h0040_0000;
        m_cause = 0; m_epc = 0; m_badv = 0; m_timer = 1'b0;
    endtask

    // One rising edge of the architecture, from the rules in prose form
    task automatic model_edge();
        logic [31:0] o_count, o_compare, code;
        logic        o_tick, o_timer, o_exl, listed;
        if (!resetn) begin
            model_reset();
            return;
        end
        o_count = m_count; o_compare = m_compare; o_tick = m_tick;
        o_timer = m_timer; o_exl = m_status[1];
        m_tick = ~o_tick;
        if (o_tick) m_count = o_count + 1;
        if (o_count == o_compare && o_compare != 0) m_timer = 1'b1;
        m_cause[15:10] = {int_i[5] | o_timer, int_i[4:0]};
        if (we_i && excepttype_i == 0) begin
            case (waddr_i)
                5'd9:  begin m_count = data_i; m_tick = 1'b0; end
                5'd11: begin m_compare = data_i; m_timer = 1'b0; end
                5'd12: m_status = (m_status & ~32'h0000_FF03) | (data_i & 32'h0000_FF03);
                5'd13: m_cause[9:8] = data_i[9:8];
                5'd14: m_epc = data_i;
                default: ;
            endcase
        end
        listed = (excepttype_i inside {32'h1, 32'h4, 32'h5, 32'h8, 32'h9, 32'ha, 32'hc});
        if (listed) begin
            code = (excepttype_i == 32'h1) ? 32'h0 : excepttype_i;
            m_cause[6:2] = code[4:0];
            m_status[1] = 1'b1;
            if (!o_exl) begin
                m_epc = in_delayslot_i ? pc_i - 32'd4 : pc_i;
                m_cause[31] = in_delayslot_i;
            end
            if (excepttype_i == 32'h4 || excepttype_i == 32'h5) m_badv = bad_addr_i;
        end else if (excepttype_i == 32'he) begin
            m_status[1] = 1'b0;
        end
    endtask

    // Drive one cycle of inputs at the falling edge and queue the prediction
    task automatic step(input logic rst, input logic we, input logic [4:0] wa,
                        input logic [31:0] d, input logic [31:0] exc, input logic [31:0] pc,
                        input logic ds, input logic [31:0] bad);
        exp_t e;
        @(negedge clk);
        resetn = rst; we_i = we; waddr_i = wa; data_i = d; excepttype_i = exc;
        pc_i = pc; in_delayslot_i = ds; bad_addr_i = bad;
        raddr_i = 5'($urandom_range(0, 15));
        int_i = 6'($urandom);
        model_edge();
        e.count = m_count; e.compare = m_compare; e.status = m_status;
        e.cause = m_cause_view(); e.epc = m_epc; e.badv = m_badv; e.timer = m_timer;
        e.data = m_read(raddr_i);
        q.push_back(e);
    endtask

    task automatic idle();
        step(1'b1, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0);
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    // Monitor: every edge presents a new state; compare it with the queued prediction
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("count_o",    count_o,    e.count);
                chk("compare_o",  compare_o,  e.compare);
                chk("status_o",   status_o,   e.status);
                chk("cause_o",    cause_o,    e.cause);
                chk("epc_o",      epc_o,      e.epc);
                chk("badvaddr_o", badvaddr_o, e.badv);
                chk("timer_int_o", 32'(timer_int_o), 32'(e.timer));
                chk("data_o",     data_o,     e.data);
            end
        end
    end

    initial begin
        logic        seen;
        logic [31:0] prev_count;
        logic [31:0] exc;
        logic [4:0]  wa;
        resetn = 1'b0; we_i = 1'b0; waddr_i = 0; raddr_i = 0; data_i = 0; int_i = 0;
        excepttype_i = 0; pc_i = 0; in_delayslot_i = 1'b0; bad_addr_i = 0;
        model_reset();

        // Reset, then ten idle cycles
        step(1'b0, 1'b1, 5'd9, 32'hDEAD_BEEF, 32'h4, 32'h1234, 1'b1, 32'h55);
        step(1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0);
        for (int i = 0; i < 10; i++) idle();
        settle();
        chk("idle10_count", count_o, 32'd5);
        chk("idle10_status", status_o, 32'h0040_0000);
        chk("idle10_cause", cause_o & 32'hFFFF_03FF, 32'h0);
        chk("idle10_timer", 32'(timer_int_o), 32'h0);

        // Timer: Compare=8, interrupt appears on the edge after Count reaches 8
        step(1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0);
        step(1'b1, 1'b1, 5'd11, 32'd8, 32'h0, 32'h0, 1'b0, 32'h0);
        settle();
        seen = 1'b0;
        prev_count = count_o;
        for (int i = 0; i < 40 && !seen; i++) begin
            idle();
            settle();
            if (timer_int_o) begin
                seen = 1'b1;
                chk("timer_rise_prev_count", prev_count, 32'd8);
            end
            prev_count = count_o;
        end
        chk("timer_rose", 32'(seen), 32'h1);
        idle();
        settle();
        chk("timer_cause15", 32'(cause_o[15]), 32'h1);
        chk("timer_cause30", 32'(cause_o[30]), 32'h1);
        step(1'b1, 1'b1, 5'd11, 32'd100, 32'h0, 32'h0, 1'b0, 32'h0);
        settle();
        chk("timer_clear", 32'(timer_int_o), 32'h0);

        // Address error in a delay slot
        step(1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 5'd0, 32'h0, 32'h4, 32'hBFC0_0100, 1'b1, 32'h3);
        settle();
        chk("adel_epc", epc_o, 32'hBFC0_00FC);
        chk("adel_bd", 32'(cause_o[31]), 32'h1);
        chk("adel_exccode", 32'(cause_o[6:2]), 32'h4);
        chk("adel_badv", badvaddr_o, 32'h3);
        chk("adel_exl", 32'(status_o[1]), 32'h1);

        // Nested syscall keeps EPC; ERET clears EXL only
        step(1'b1, 1'b0, 5'd0, 32'h0, 32'h8, 32'h8000_0010, 1'b0, 32'h77);
        settle();
        chk("nested_epc", epc_o, 32'hBFC0_00FC);
        chk("nested_exccode", 32'(cause_o[6:2]), 32'h8);
        chk("nested_badv", badvaddr_o, 32'h3);
        step(1'b1, 1'b0, 5'd0, 32'h0, 32'he, 32'h8000_0020, 1'b1, 32'h0);
        settle();
        chk("eret_exl", 32'(status_o[1]), 32'h0);
        chk("eret_epc", epc_o, 32'hBFC0_00FC);

        // Exception suppresses MTC0 to EPC; Status write mask
        step(1'b1, 1'b1, 5'd14, 32'h1234_5678, 32'hc, 32'h0040_0020, 1'b0, 32'h0);
        settle();
        chk("suppress_epc", epc_o, 32'h0040_0020);
        step(1'b1, 1'b1, 5'd12, 32'hFFFF_FFFF, 32'h0, 32'h0, 1'b0, 32'h0);
        settle();
        chk("status_mask", status_o, 32'h0040_FF03);

        // Count wrap
        step(1'b1, 1'b1, 5'd9, 32'hFFFF_FFFF, 32'h0, 32'h0, 1'b0, 32'h0);
        idle();
        idle();
        settle();
        chk("count_wrap", count_o, 32'h0);

        // Randomised traffic against the model
        for (int i = 0; i < 600; i++) begin
            case ($urandom_range(0, 11))
                0, 1:    exc = 32'h0 | {28'h0, 4'($urandom_range(1, 15))};
                2:       exc = $urandom;
                3:       exc = 32'he;
                default: exc = 32'h0;
            endcase
            case ($urandom_range(0, 7))
                0: wa = 5'd8;  1: wa = 5'd9;  2: wa = 5'd11; 3: wa = 5'd12;
                4: wa = 5'd13; 5: wa = 5'd14; default: wa = 5'($urandom);
            endcase
            step(($urandom_range(0, 59) != 0), 1'($urandom), wa,
                 ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom,
                 exc, $urandom, 1'($urandom), $urandom);
        end

        settle();
        settle();
        chk("queue_drained", 32'(q.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cp0_reg.md
CP0_REG -- requirements
Module: cp0_reg

Interface
REQ-001 SHALL provide port: clk  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL provide port: resetn  input  1  synchronous, active-low reset.
REQ-003 SHALL provide ports: we_i  input  1  MTC0 write enable; waddr_i  input  5  write register number; raddr_i  input  5  MFC0 read register number; data_i  input  32  MTC0 write data.
REQ-004 SHALL provide ports: int_i  input  6  external hardware interrupt lines.
REQ-005 SHALL provide ports: excepttype_i  input  32  exception code from the M-stage exception unit (0 = none); pc_i  input  32  PC of the excepting M-stage instruction; in_delayslot_i  input  1  that instruction is in a delay slot; bad_addr_i  input  32  faulting address.
REQ-006 SHALL provide ports: data_o  output  32  MFC0 read data; count_o, compare_o, status_o, cause_o, epc_o, badvaddr_o  output  32 each  register contents; timer_int_o  output  1  timer interrupt pending.

Function
REQ-007 SHALL implement registers BadVAddr(8), Count(9), Compare(11), Status(12), Cause(13), EPC(14); all other numbers read as 32'h0 and ignore writes.
REQ-008 SHALL drive data_o combinationally from raddr_i and the current register values; no same-cycle write bypass.
REQ-009 SHALL keep a 1-bit tick toggling every cycle; Count SHALL increment when tick==1, i.e. once every 2 cycles, wrapping 32'hFFFFFFFF -> 0.
REQ-010 SHALL set timer_int_o on the edge after Count==Compare while Compare!=0, hold it until cleared, and clear it on any MTC0 write to Compare.
REQ-011 SHALL update Cause[15:10] every cycle to {int_i[5] | timer_int_o, int_i[4:0]}; Cause[30] (TI) SHALL mirror timer_int_o.
REQ-012 MTC0 (we_i=1, no exception this cycle) SHALL write: Count all bits, with tick cleared to 0; Compare all bits; Status bits [15:8], [1], [0] only; Cause bits [9:8] only; EPC all bits; BadVAddr not writable.
REQ-013 An MTC0 write to Count SHALL take priority over the same-cycle increment.
REQ-014 Exception codes 1,4,5,8,9,a,c SHALL set Cause[6:2] ExcCode to 00,04,05,08,09,0a,0c (hex) respectively and set Status[1] (EXL)=1.
REQ-015 On those exceptions with EXL==0 beforehand: EPC <= in_delayslot_i ? pc_i-4 : pc_i; Cause[31] (BD) <= in_delayslot_i. With EXL already 1, EPC and BD SHALL be unchanged.
REQ-016 Codes 4 and 5 SHALL also load BadVAddr <= bad_addr_i; other codes leave BadVAddr unchanged.
REQ-017 Code e (ERET) SHALL clear Status[1] and change nothing else.
REQ-018 Any nonzero excepttype_i SHALL suppress a same-cycle MTC0 write entirely; Count increment and Cause[15:10] sampling continue.
REQ-019 Unlisted nonzero excepttype_i values SHALL be ignored, with the MTC0 write still suppressed.
REQ-020 Status bits other than [15:8], [1], [0] SHALL hold their reset value permanently; Status[22] (BEV) reads 1.

Reset
REQ-021 While resetn==0 at a rising edge: Count=0, Compare=0, Status=32'h0040_0000, Cause=0, EPC=0, BadVAddr=0, tick=0, timer_int_o=0.
REQ-022 Reset SHALL override any same-cycle MTC0 write, exception or increment; outputs reflect reset values on the cycle after the edge.

Verification
REQ-023 Reset, then 10 idle cycles -> count_o=5, status_o=32'h0040_0000, cause_o=0, timer_int_o=0.
REQ-024 MTC0 Compare=8 after reset -> timer_int_o rises the edge after count_o==8; cause_o[15]=1, cause_o[30]=1; MTC0 Compare=100 -> timer_int_o=0 next cycle.
REQ-025 excepttype_i=4, pc_i=32'hBFC0_0100, in_delayslot_i=1, bad_addr_i=32'h0000_0003 -> epc_o=32'hBFC0_00FC, cause_o[31]=1, cause_o[6:2]=4, badvaddr_o=3, status_o[1]=1.
REQ-026 With EXL=1, excepttype_i=8, pc_i=32'h8000_0010 -> epc_o unchanged, ExcCode=8; then excepttype_i=e -> status_o[1]=0, EPC unchanged.
REQ-027 Same cycle we_i=1, waddr_i=14, data_i=32'h1234_5678 and excepttype_i=c -> EPC=pc_i (not 32'h1234_5678); MTC0 Status=32'hFFFF_FFFF alone -> status_o=32'h0040_FF03.
